// File: rtl/result_pkg.sv
// Shared sizes, tile type and FSM state encoding for the result writer slice.
package result_pkg;

  localparam int TILE_DIM = 4;
  localparam int ELEM_W   = 24;
  localparam int WORD_W   = 512;
  localparam int ADDR_W   = 8;
  localparam int LANE_W   = WORD_W / (TILE_DIM * TILE_DIM);

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef elem_t [TILE_DIM-1:0][TILE_DIM-1:0] tile_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WR1,
    WR2,
    DONE
  } state_t;

endpackage

// File: rtl/result_tile_pack.sv
// Packs one PE tile into an SRAM word: element [r][c] lands at word[(r*4+c)*32 +: 32].
// Build option RESULT_RELU_EN clamps negative elements to zero before packing.
module result_tile_pack
  import result_pkg::*;
(
  input  tile_t             tile,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int r = 0; r < TILE_DIM; r++) begin
      for (int c = 0; c < TILE_DIM; c++) begin
`ifdef RESULT_RELU_EN
        if (tile[r][c][ELEM_W-1]) begin
          word[(r*TILE_DIM+c)*LANE_W +: LANE_W] = '0;
        end else begin
          word[(r*TILE_DIM+c)*LANE_W +: LANE_W] =
            {{(LANE_W-ELEM_W){1'b0}}, tile[r][c]};
        end
`else
        word[(r*TILE_DIM+c)*LANE_W +: LANE_W] =
          {{(LANE_W-ELEM_W){tile[r][c][ELEM_W-1]}}, tile[r][c]};
`endif
      end
    end
  end

endmodule

// File: rtl/result_writer.sv
// Result writer: takes PE tile pairs and writes lane 1 then lane 2 to SRAM, with a
// scan readout path. Build option RESULT_RELU_EN is applied inside result_tile_pack.
//
// state | meaning
// IDLE  | waiting for output_prepare_i
// RUN   | ready for the next tile pair (unless scan_mode)
// WR1   | writing lane-1 tile
// WR2   | writing lane-2 tile, counting the pair
// DONE  | one-cycle loop_finished_o pulse
module result_writer
  import result_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              output_prepare_i,
  input  logic [7:0]        tile_total_i,
  input  tile_t             result_tile_i_1,
  input  tile_t             result_tile_i_2,
  input  logic [ADDR_W-1:0] result_addr_i_1,
  input  logic [ADDR_W-1:0] result_addr_i_2,
  input  logic              result_valid_i,
  output logic              result_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  input  logic              scan_mode,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [WORD_W-1:0] rd_data_i,
  output logic [WORD_W-1:0] scan_out,
  output logic              loop_finished_o,
  output logic [7:0]        pair_cnt_o
);

  state_t            state_q, state_d;
  tile_t             tile1_q, tile2_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic [7:0]        total_q, pair_cnt_q, pair_cnt_inc;
  logic [WORD_W-1:0] word1, word2;
  logic              accept, start, rd_pend_q;

  assign result_ready_o = (state_q == RUN) & ~scan_mode;
  assign accept         = result_ready_o & result_valid_i;
  assign start          = (state_q == IDLE) & output_prepare_i;
  assign pair_cnt_inc   = pair_cnt_q + 8'd1;
  assign pair_cnt_o     = pair_cnt_q;

  result_tile_pack u_pack_1 (.tile(tile1_q), .word(word1));
  result_tile_pack u_pack_2 (.tile(tile2_q), .word(word2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    wr_en_o         = 1'b0;
    wr_addr_o       = '0;
    wr_data_o       = '0;
    loop_finished_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (output_prepare_i) state_d = (tile_total_i == 8'd0) ? DONE : RUN;
      end
      RUN: begin
        if (accept) state_d = WR1;
      end
      WR1: begin
        wr_en_o   = 1'b1;
        wr_addr_o = addr1_q;
        wr_data_o = word1;
        state_d   = WR2;
      end
      WR2: begin
        wr_en_o   = 1'b1;
        wr_addr_o = addr2_q;
        wr_data_o = word2;
        state_d   = (pair_cnt_inc == total_q) ? DONE : RUN;
      end
      DONE: begin
        loop_finished_o = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q    <= '0;
      pair_cnt_q <= '0;
      tile1_q    <= '0;
      tile2_q    <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
    end else begin
      if (start) begin
        total_q    <= tile_total_i;
        pair_cnt_q <= '0;
      end
      if (accept) begin
        tile1_q <= result_tile_i_1;
        tile2_q <= result_tile_i_2;
        addr1_q <= result_addr_i_1;
        addr2_q <= result_addr_i_2;
      end
      if (state_q == WR2) pair_cnt_q <= pair_cnt_inc;
    end
  end

  // Scan reads are independent of the FSM; SRAM data returns one cycle after rd_en_o.
  assign rd_en_o   = scan_mode & ~reset;
  assign rd_addr_o = rd_en_o ? scan_addr : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      scan_out  <= '0;
    end else begin
      rd_pend_q <= scan_mode;
      if (rd_pend_q) scan_out <= rd_data_i;
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: vector table plus scoreboard of expected SRAM writes.
module tb_result_writer;
  import result_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              output_prepare_i;
  logic [7:0]        tile_total_i;
  tile_t             result_tile_i_1, result_tile_i_2;
  logic [ADDR_W-1:0] result_addr_i_1, result_addr_i_2;
  logic              result_valid_i;
  logic              result_ready_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [WORD_W-1:0] wr_data_o;
  logic              scan_mode;
  logic [ADDR_W-1:0] scan_addr;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [WORD_W-1:0] rd_data_i = '0;
  logic [WORD_W-1:0] scan_out;
  logic              loop_finished_o;
  logic [7:0]        pair_cnt_o;

  logic [WORD_W-1:0] mem [256];
  logic [WORD_W-1:0] mem_pre = {16{32'hC0DE_0030}};
  logic [WORD_W-1:0] last_wr_data = '0;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  int  wr_cyc_q[$];

  typedef struct {
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    int                s1;
    int                s2;
    int                exp_writes;
    int                exp_cnt;
  } vec_t;
  vec_t vecs[4];

  result_writer dut (
    .clk(clk), .reset(reset),
    .output_prepare_i(output_prepare_i), .tile_total_i(tile_total_i),
    .result_tile_i_1(result_tile_i_1), .result_tile_i_2(result_tile_i_2),
    .result_addr_i_1(result_addr_i_1), .result_addr_i_2(result_addr_i_2),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .scan_mode(scan_mode), .scan_addr(scan_addr),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .scan_out(scan_out), .loop_finished_o(loop_finished_o), .pair_cnt_o(pair_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
  end

  task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic tile_t make_tile(input int seed);
    tile_t t;
    int v;
    t = '0;
    if (seed == 0) begin
      t[3][3] = '1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        v = seed * 4099 - i * 70001;
        t[i/4][i%4] = v[23:0];
      end
    end
    return t;
  endfunction

  function automatic logic [WORD_W-1:0] model_pack(input tile_t t);
    logic [WORD_W-1:0] w;
    logic signed [23:0] e;
    int v;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      e = t[i/4][i%4];
`ifdef RESULT_RELU_EN
      if (e < 0) e = '0;
`endif
      v = e;
      w[i*32 +: 32] = v;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (loop_finished_o) done_cnt++;
    if (wr_en_o) begin
      wr_cyc_q.push_back(cyc);
      last_wr_data = wr_data_o;
      if (exp_q.size() == 0) begin
        fail("unexpected_write", $sformatf("addr %0h with no expected write", wr_addr_o));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr_o, e.addr);
        check("wr_data", wr_data_o, e.data);
      end
    end
  end

  task automatic prepare(input logic [7:0] total, output int pc);
    output_prepare_i = 1'b1;
    tile_total_i     = total;
    pc               = cyc;
    @(negedge clk);
    output_prepare_i = 1'b0;
  endtask

  // Offers a pair (valid left high) and pushes the expected lane writes on acceptance.
  task automatic send_pair(input int s1, input int s2, input logic [7:0] a1,
                           input logic [7:0] a2, output int acc);
    tile_t t1, t2;
    wr_t   w;
    int    n = 0;
    t1 = make_tile(s1);
    t2 = make_tile(s2);
    result_tile_i_1 = t1;
    result_tile_i_2 = t2;
    result_addr_i_1 = a1;
    result_addr_i_2 = a2;
    result_valid_i  = 1'b1;
    acc = -1;
    #1;
    while (!result_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!result_ready_o) begin
      fail("accept_timeout", "result_ready_o never rose");
    end else begin
      acc = cyc;
      w.addr = a1; w.data = model_pack(t1); exp_q.push_back(w);
      w.addr = a2; w.data = model_pack(t2); exp_q.push_back(w);
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    dc = -1;
    while (!loop_finished_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (loop_finished_o) dc = cyc;
    else fail("done_timeout", "loop_finished_o never pulsed");
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, a0, a1, dc, d0;
    logic [WORD_W-1:0] hold;
    logic [31:0] exp33;

    vecs[0] = '{8'h10, 8'h11, 3, 5, 2, 1};
    vecs[1] = '{8'hFF, 8'h00, -7, 11, 2, 1};
    vecs[2] = '{8'h42, 8'h42, 100, -100, 2, 1};
    vecs[3] = '{8'h01, 8'h80, 12345, 0, 2, 1};
`ifdef RESULT_RELU_EN
    exp33 = 32'h0000_0000;
`else
    exp33 = 32'hFFFF_FFFF;
`endif

    reset = 1'b1;
    output_prepare_i = 1'b0;
    tile_total_i = '0;
    result_tile_i_1 = '0;
    result_tile_i_2 = '0;
    result_addr_i_1 = '0;
    result_addr_i_2 = '0;
    result_valid_i = 1'b0;
    scan_mode = 1'b1;
    scan_addr = 8'h33;
    mem[8'h30] = mem_pre;
    tick(2);

    check("rst_ready", result_ready_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_rd_en", rd_en_o, 0);
    check("rst_rd_addr", rd_addr_o, 0);
    check("rst_scan_out", scan_out, 0);
    check("rst_done", loop_finished_o, 0);
    check("rst_cnt", pair_cnt_o, 0);
    scan_mode = 1'b0;
    reset = 1'b0;
    tick(1);

    // two pairs, valid held high
    wr_cyc_q.delete();
    d0 = done_cnt;
    prepare(8'd2, pc);
    send_pair(11, 12, 8'd5, 8'd6, a0);
    check("first_accept", a0 - pc, 1);
    check("ready_low_wr1", result_ready_o, 0);
    send_pair(13, 14, 8'd7, 8'd8, a1);
    result_valid_i = 1'b0;
    check("accept_spacing", a1 - a0, 3);
    wait_done(dc);
    check("done_cycle", dc - a0, 6);
    check("done_one_cycle", loop_finished_o, 0);
    check("job1_writes", wr_cyc_q.size(), 4);
    if (wr_cyc_q.size() == 4) begin
      check("wr_cyc0", wr_cyc_q[0] - a0, 1);
      check("wr_cyc1", wr_cyc_q[1] - a0, 2);
      check("wr_cyc2", wr_cyc_q[2] - a0, 4);
      check("wr_cyc3", wr_cyc_q[3] - a0, 5);
    end
    check("job1_cnt", pair_cnt_o, 2);
    tick(1);
    check("job1_pulses", done_cnt - d0, 1);
    check("job1_sb_empty", exp_q.size(), 0);

    // zero-length job
    wr_cyc_q.delete();
    d0 = done_cnt;
    prepare(8'd0, pc);
    check("zero_done_now", loop_finished_o, 1);
    tick(1);
    check("zero_done_end", loop_finished_o, 0);
    tick(3);
    check("zero_writes", wr_cyc_q.size(), 0);
    check("zero_cnt", pair_cnt_o, 0);
    check("zero_pulses", done_cnt - d0, 1);

    for (int i = 0; i < 4; i++) begin
      wr_cyc_q.delete();
      prepare(8'd1, pc);
      send_pair(vecs[i].s1, vecs[i].s2, vecs[i].a1, vecs[i].a2, a0);
      result_valid_i = 1'b0;
      wait_done(dc);
      check($sformatf("vec%0d_writes", i), wr_cyc_q.size(), vecs[i].exp_writes);
      check($sformatf("vec%0d_cnt", i), pair_cnt_o, vecs[i].exp_cnt);
    end
    check("elem33", last_wr_data[511:480], exp33);

    // scan raised the cycle after accept: in-flight pair completes
    wr_cyc_q.delete();
    prepare(8'd1, pc);
    send_pair(21, 22, 8'h20, 8'h21, a0);
    result_valid_i = 1'b0;
    scan_mode = 1'b1;
    scan_addr = 8'h30;
    #1;
    check("scan_ready_low", result_ready_o, 0);
    check("scan_rd_en", rd_en_o, 1);
    check("scan_rd_addr", rd_addr_o, 8'h30);
    wait_done(dc);
    check("scan_writes", wr_cyc_q.size(), 2);
    check("scan_out_pre", scan_out, mem_pre);
    scan_addr = 8'h21;
    tick(1);
    check("scan_out_latency", scan_out, mem_pre);
    tick(1);
    check("scan_out_lane2", scan_out, model_pack(make_tile(22)));
    scan_addr = 8'h20;
    tick(2);
    check("scan_out_lane1", scan_out, model_pack(make_tile(21)));

    // scan held high blocks acceptance in RUN
    prepare(8'd1, pc);
    result_tile_i_1 = make_tile(31);
    result_valid_i = 1'b1;
    tick(4);
    check("scan_block_ready", result_ready_o, 0);
    check("scan_block_writes", wr_cyc_q.size(), 2);
    hold = scan_out;
    scan_mode = 1'b0;
    send_pair(31, 32, 8'h50, 8'h51, a0);
    result_valid_i = 1'b0;
    wait_done(dc);
    check("scan_off_rd_en", rd_en_o, 0);
    check("scan_off_rd_addr", rd_addr_o, 0);
    check("scan_out_hold", scan_out, hold);
    check("scan_off_cnt", pair_cnt_o, 1);

    // output_prepare_i during RUN is ignored
    wr_cyc_q.delete();
    d0 = done_cnt;
    prepare(8'd2, pc);
    output_prepare_i = 1'b1;
    tile_total_i = 8'd1;
    tick(1);
    output_prepare_i = 1'b0;
    send_pair(41, 42, 8'h60, 8'h61, a0);
    result_valid_i = 1'b0;
    tick(4);
    check("runprep_no_done", done_cnt - d0, 0);
    check("runprep_cnt1", pair_cnt_o, 1);
    check("runprep_ready", result_ready_o, 1);
    send_pair(43, 44, 8'h62, 8'h63, a1);
    result_valid_i = 1'b0;
    wait_done(dc);
    check("runprep_cnt2", pair_cnt_o, 2);
    check("runprep_writes", wr_cyc_q.size(), 4);

    // reset in WR1 abandons the job
    d0 = done_cnt;
    prepare(8'd2, pc);
    send_pair(51, 52, 8'h70, 8'h71, a0);
    result_valid_i = 1'b0;
    tick(2);
    check("rstjob_cnt1", pair_cnt_o, 1);
    send_pair(53, 54, 8'h72, 8'h73, a1);
    result_valid_i = 1'b0;
    check("rstjob_wr1", wr_en_o, 1);
    #1;
    reset = 1'b1;
    #1;
    check("rstjob_async_wr_en", wr_en_o, 0);
    check("rstjob_async_cnt", pair_cnt_o, 0);
    check("rstjob_async_done", loop_finished_o, 0);
    exp_q.delete();
    wr_cyc_q.delete();
    tick(2);
    reset = 1'b0;
    tick(4);
    check("rstjob_no_writes", wr_cyc_q.size(), 0);
    check("rstjob_no_done", done_cnt - d0, 0);
    check("rstjob_idle_ready", result_ready_o, 0);
    check("rstjob_idle_cnt", pair_cnt_o, 0);

    prepare(8'd1, pc);
    send_pair(61, 62, 8'h74, 8'h75, a0);
    result_valid_i = 1'b0;
    wait_done(dc);
    check("recover_cnt", pair_cnt_o, 1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
